mem_arbiter: RTL and testbench

Arbitrates the single shared RAM port between the instruction-fetch requester and the data request unit of the pipelined processor. Selects one requester per access, drives the RAM port until the RAM signals completion, returns read data and releases the winner's wait line. Data accesses have priority. A streak counter prevents fetch starvation. Sits between the request unit / fetch stage and the RAM model.

---
 rtl/mem_arbiter_if.sv | 38 +++
 rtl/mem_arbiter.sv | 108 ++++++++++
 tb/tb_mem_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of signals between the arbiter, its two requesters and the shared RAM port.
// The slave modport is the arbiter's view; master is the requester/RAM side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Instruction-fetch requester
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              iwait;
    logic [DATA_W-1:0] iload;

    // Data requester
    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic              dwait;
    logic [DATA_W-1:0] dload;

    // Shared RAM port
    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload;
    logic              ramready;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one RAM port between instruction fetch and data accesses.
// Data wins arbitration, except that after MAX_DSTREAK back-to-back data
// grants with fetch waiting, fetch is forced through once.
module mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_DSTREAK = 4
) (
    input  logic          CLK,
    input  logic          RST,
    mem_arbiter_if.slave  bus
);
    localparam int SW = $clog2(MAX_DSTREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t            state_q;
    logic [SW-1:0]     dstreak_q;
    logic [SW-1:0]     dstreak_d;
    logic              wr_q;       // latched data access type: 1 = write
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] store_q;
    logic [DATA_W-1:0] iload_q;
    logic [DATA_W-1:0] dload_q;

    logic d_req;
    logic done_i;
    logic done_d;
    logic pick_d;

    assign d_req  = bus.dREN | bus.dWEN;
    assign done_i = (state_q == GRANT_I) && bus.ramready;
    assign done_d = (state_q == GRANT_D) && bus.ramready;
    // Data wins unless fetch is pending and has already waited out a full streak
    assign pick_d = d_req && !(bus.iREN && (dstreak_q == STREAK_MAX));

    // Streak of data completions while fetch waits; any idle fetch cycle resets it
    always_comb begin
        dstreak_d = dstreak_q;
        if (!bus.iREN || done_i) begin
            dstreak_d = '0;
        end else if (done_d && (dstreak_q != STREAK_MAX)) begin
            dstreak_d = dstreak_q + 1'b1;
        end
    end

    // Arbitration FSM: latch the winner's request on grant, capture load data on completion
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            dstreak_q <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            store_q   <= '0;
            iload_q   <= '0;
            dload_q   <= '0;
        end else begin
            dstreak_q <= dstreak_d;
            case (state_q)
                IDLE: begin
                    if (pick_d) begin
                        state_q <= GRANT_D;
                        wr_q    <= bus.dWEN;   // write takes precedence over a concurrent read
                        addr_q  <= bus.daddr;
                        store_q <= bus.dstore;
                    end else if (bus.iREN) begin
                        state_q <= GRANT_I;
                        wr_q    <= 1'b0;
                        addr_q  <= bus.iaddr;
                    end
                end
                GRANT_I: begin
                    if (bus.ramready) begin
                        state_q <= IDLE;
                        // A dropped request still completes, but its data is discarded
                        if (bus.iREN) begin
                            iload_q <= bus.ramload;
                        end
                    end
                end
                GRANT_D: begin
                    if (bus.ramready) begin
                        state_q <= IDLE;
                        if (!wr_q && bus.dREN) begin
                            dload_q <= bus.ramload;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Strobes and wait lines are forced low during reset so an aborted access stops at once
    assign bus.ramREN   = !RST && ((state_q == GRANT_I) || ((state_q == GRANT_D) && !wr_q));
    assign bus.ramWEN   = !RST && (state_q == GRANT_D) && wr_q;
    assign bus.ramaddr  = addr_q;
    assign bus.ramstore = store_q;
    assign bus.iwait    = !RST && bus.iREN && !done_i;
    assign bus.dwait    = !RST && d_req && !done_d;
    assign bus.iload    = iload_q;
    assign bus.dload    = dload_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios followed by a randomized phase checked against a
// transaction-level model of the arbitration rules.
module tb_mem_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXS = 4;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DSTREAK(MAXS)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Reference model state for the random phase
    int          streak_m;
    int          owner;      // 0 none, 1 fetch, 2 data
    int          lat;
    bit          busy, prev_busy, rdy, win_d, own_w, i_done, d_done;
    bit          p_i, p_d, p_w;
    logic [31:0] p_iaddr, p_daddr, p_dstore;
    logic [31:0] exp_il, exp_dl;

    initial begin
        bus.iREN = 1'b0; bus.iaddr = '0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
        bus.daddr = '0; bus.dstore = '0; bus.ramload = '0; bus.ramready = 1'b0;

        // ---- Reset with both requests pending ----
        RST = 1'b1; bus.iREN = 1'b1; bus.dREN = 1'b1;
        bus.iaddr = 32'h10; bus.daddr = 32'h20; bus.ramload = 32'h0BAD_F00D;
        cyc(); cyc(); #2;
        chk("rst_iwait", bus.iwait, 0);
        chk("rst_dwait", bus.dwait, 0);
        chk("rst_ramREN", bus.ramREN, 0);
        chk("rst_ramWEN", bus.ramWEN, 0);
        chk("rst_ramaddr", bus.ramaddr, 0);
        chk("rst_ramstore", bus.ramstore, 0);
        chk("rst_iload", bus.iload, 0);
        chk("rst_dload", bus.dload, 0);
        RST = 1'b0;
        cyc(); #2;
        chk("rel_ramREN", bus.ramREN, 1);
        chk("rel_ramaddr", bus.ramaddr, 32'h20);
        chk("rel_iwait", bus.iwait, 1);
        bus.ramready = 1'b1; #1;
        chk("rel_dwait", bus.dwait, 0);
        cyc(); bus.ramready = 1'b0; bus.dREN = 1'b0; bus.iREN = 1'b0; #2;
        chk("rel_dload", bus.dload, 32'h0BAD_F00D);

        // ---- Single fetch, ready three cycles into the grant ----
        cyc(); bus.iREN = 1'b1; bus.iaddr = 32'h40; #2;
        chk("sf_idle_ren", bus.ramREN, 0);
        chk("sf_idle_iwait", bus.iwait, 1);
        for (int k = 0; k < 3; k++) begin
            cyc();
            bus.ramready = (k == 2);
            bus.ramload  = (k == 2) ? 32'hDEAD_BEEF : 32'h0;
            #2;
            chk("sf_ramREN", bus.ramREN, 1);
            chk("sf_ramaddr", bus.ramaddr, 32'h40);
            chk("sf_iwait", bus.iwait, (k != 2));
        end
        cyc(); bus.iREN = 1'b0; bus.ramready = 1'b0; #2;
        chk("sf_iload", bus.iload, 32'hDEAD_BEEF);
        chk("sf_after_ren", bus.ramREN, 0);

        // ---- Write beats fetch, fetch follows after one idle cycle ----
        bus.iREN = 1'b1; bus.iaddr = 32'h80;
        bus.dWEN = 1'b1; bus.daddr = 32'h100; bus.dstore = 32'h1234;
        cyc(); bus.ramready = 1'b1; #2;
        chk("wp_ramWEN", bus.ramWEN, 1);
        chk("wp_ramREN", bus.ramREN, 0);
        chk("wp_ramaddr", bus.ramaddr, 32'h100);
        chk("wp_ramstore", bus.ramstore, 32'h1234);
        chk("wp_dwait", bus.dwait, 0);
        chk("wp_iwait", bus.iwait, 1);
        cyc(); bus.dWEN = 1'b0; bus.ramready = 1'b0; #2;
        chk("wp_idle_wen", bus.ramWEN, 0);
        chk("wp_idle_ren", bus.ramREN, 0);
        cyc(); bus.ramready = 1'b1; bus.ramload = 32'hA5A5_A5A5; #2;
        chk("wp_f_ramREN", bus.ramREN, 1);
        chk("wp_f_ramaddr", bus.ramaddr, 32'h80);
        chk("wp_f_iwait", bus.iwait, 0);
        cyc(); bus.iREN = 1'b0; bus.ramready = 1'b0; #2;
        chk("wp_iload", bus.iload, 32'hA5A5_A5A5);

        // ---- Starvation bound: both requests held, ready immediate ----
        bus.iREN = 1'b1; bus.iaddr = 32'h200;
        bus.dREN = 1'b1; bus.daddr = 32'h300;
        bus.ramready = 1'b1; bus.ramload = 32'h1111_2222;
        streak_m = 0;
        for (int g = 0; g < 10; g++) begin
            cyc(); #2;
            chk("sb_ramREN", bus.ramREN, 1);
            chk("sb_winner", bus.ramaddr, (streak_m == MAXS) ? 32'h200 : 32'h300);
            if (streak_m == MAXS) streak_m = 0;
            else                  streak_m = streak_m + 1;
            cyc(); #2;
            chk("sb_idle", bus.ramREN, 0);
        end
        bus.iREN = 1'b0; bus.dREN = 1'b0; bus.ramready = 1'b0;

        // ---- Data read dropped mid-grant ----
        cyc(); bus.dREN = 1'b1; bus.daddr = 32'h400; #2;
        chk("dr_idle", bus.ramREN, 0);
        cyc(); #2;
        chk("dr_ramREN", bus.ramREN, 1);
        chk("dr_ramaddr", bus.ramaddr, 32'h400);
        bus.dREN = 1'b0; #1;
        chk("dr_dwait", bus.dwait, 0);
        cyc(); bus.ramready = 1'b1; bus.ramload = 32'h5555_5555; #2;
        chk("dr_runs", bus.ramREN, 1);
        cyc(); bus.ramready = 1'b0; bus.iREN = 1'b1; bus.iaddr = 32'h500; #2;
        chk("dr_done", bus.ramREN, 0);
        chk("dr_dload", bus.dload, 32'h1111_2222);
        cyc(); bus.ramready = 1'b1; bus.ramload = 32'h77; #2;
        chk("dr_next_ren", bus.ramREN, 1);
        chk("dr_next_addr", bus.ramaddr, 32'h500);
        chk("dr_next_iwait", bus.iwait, 0);
        cyc(); bus.iREN = 1'b0; bus.ramready = 1'b0; #2;
        chk("dr_next_iload", bus.iload, 32'h77);

        // ---- Reset during a fetch grant ----
        bus.iREN = 1'b1; bus.iaddr = 32'h600;
        cyc(); #2;
        chk("rm_ramREN", bus.ramREN, 1);
        RST = 1'b1; #1;
        chk("rm_ren_now", bus.ramREN, 0);
        chk("rm_iwait_now", bus.iwait, 0);
        cyc(); #2;
        chk("rm_ren_next", bus.ramREN, 0);
        chk("rm_iwait", bus.iwait, 0);
        chk("rm_iload", bus.iload, 0);
        chk("rm_dload", bus.dload, 0);
        RST = 1'b0; bus.iREN = 1'b0;
        cyc();

        // ---- Randomized traffic against the transaction-level model ----
        prev_busy = 0; p_i = 0; p_d = 0; p_w = 0;
        p_iaddr = '0; p_daddr = '0; p_dstore = '0;
        streak_m = 0; owner = 0; lat = 0; own_w = 0;
        exp_il = '0; exp_dl = '0; i_done = 0; d_done = 0;
        for (int n = 0; n < 600; n++) begin
            cyc();
            if (i_done) bus.iREN = 1'b0;
            if (d_done) begin bus.dREN = 1'b0; bus.dWEN = 1'b0; end
            if (!bus.iREN && $urandom_range(0, 2) == 0) begin
                bus.iREN = 1'b1; bus.iaddr = $urandom;
            end
            if (!bus.dREN && !bus.dWEN && $urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 2) == 0) begin
                    bus.dWEN = 1'b1; bus.dREN = 1'($urandom_range(0, 1));
                end else begin
                    bus.dREN = 1'b1;
                end
                bus.daddr = $urandom; bus.dstore = $urandom;
            end
            bus.ramload = $urandom;
            busy = bus.ramREN | bus.ramWEN;
            if (busy && !prev_busy) begin
                win_d = p_d && !(p_i && streak_m == MAXS);
                owner = win_d ? 2 : 1;
                own_w = win_d && p_w;
                chk("rnd_addr", bus.ramaddr, win_d ? p_daddr : p_iaddr);
                chk("rnd_wen", bus.ramWEN, own_w);
                chk("rnd_ren", bus.ramREN, !own_w);
                if (own_w) chk("rnd_store", bus.ramstore, p_dstore);
                lat = $urandom_range(0, 3);
            end
            rdy = busy && (lat == 0);
            if (busy && lat > 0) lat--;
            bus.ramready = rdy || (!busy && $urandom_range(0, 7) == 0);
            #1;
            i_done = bus.iREN && owner == 1 && rdy;
            d_done = (bus.dREN || bus.dWEN) && owner == 2 && rdy;
            chk("rnd_iwait", bus.iwait, bus.iREN && !i_done);
            chk("rnd_dwait", bus.dwait, (bus.dREN || bus.dWEN) && !d_done);
            chk("rnd_iload", bus.iload, exp_il);
            chk("rnd_dload", bus.dload, exp_dl);
            if (i_done) exp_il = bus.ramload;
            if (d_done && !own_w) exp_dl = bus.ramload;
            if (!bus.iREN || (owner == 1 && rdy)) streak_m = 0;
            else if (owner == 2 && rdy && streak_m < MAXS) streak_m++;
            if (rdy) owner = 0;
            prev_busy = busy;
            p_i = bus.iREN; p_d = bus.dREN || bus.dWEN; p_w = bus.dWEN;
            p_iaddr = bus.iaddr; p_daddr = bus.daddr; p_dstore = bus.dstore;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
